// File: rtl/disc_acq_controller_if.sv
// Bundle of host command, reader stream, RAM write port and status signals
// around the disc acquisition sequencer.
interface disc_acq_controller_if #(
  parameter int BITS      = 8,
  parameter int ADDR_BITS = 19
);
  // Host commands and reader stream. START/ABORT/FD_INDEX_IN/MDR_WRITE are
  // single-cycle qualifiers: an item counts in exactly the cycle its strobe
  // is high at the rising edge. There is no back-pressure; the controller
  // takes or drops every strobe in that cycle.
  logic                 START;
  logic                 ABORT;
  logic                 WAIT_INDEX;
  logic [7:0]           INDEX_COUNT;
  logic                 FD_INDEX_IN;
  logic [BITS-1:0]      MDR_DATA;
  logic                 MDR_WRITE;
  logic                 MDR_RUN;
  logic [ADDR_BITS-1:0] RAM_ADDR;
  logic [BITS-1:0]      RAM_DATA;
  logic                 RAM_WE;
  logic                 BUSY;
  logic                 WAITING;
  logic                 DONE;
  logic                 ABORTED;
  logic                 MEM_FULL;
  logic [7:0]           INDEX_SEEN;
  logic [ADDR_BITS:0]   LENGTH;
  logic [1:0]           DBG_STATE;

  modport master (
    output START, ABORT, WAIT_INDEX, INDEX_COUNT, FD_INDEX_IN, MDR_DATA, MDR_WRITE,
    input  MDR_RUN, RAM_ADDR, RAM_DATA, RAM_WE, BUSY, WAITING, DONE, ABORTED,
           MEM_FULL, INDEX_SEEN, LENGTH, DBG_STATE
  );

  modport slave (
    input  START, ABORT, WAIT_INDEX, INDEX_COUNT, FD_INDEX_IN, MDR_DATA, MDR_WRITE,
    output MDR_RUN, RAM_ADDR, RAM_DATA, RAM_WE, BUSY, WAITING, DONE, ABORTED,
           MEM_FULL, INDEX_SEEN, LENGTH, DBG_STATE
  );
endinterface

// File: rtl/disc_acq_controller.sv
// Sequences one disc acquisition: arms on an index pulse, streams reader words
// into acquisition RAM and stops on index count, RAM full or abort.
module disc_acq_controller #(
  parameter int BITS      = 8,
  parameter int ADDR_BITS = 19
) (
  input logic                  CLOCK,
  input logic                  RESET,
  disc_acq_controller_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_ACQUIRE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS:0]   LEN_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_index_count;
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] r_ram_addr;
  logic [BITS-1:0]      r_ram_data;
  logic                 r_ram_we;
  logic [ADDR_BITS:0]   r_length;
  logic [7:0]           r_index_seen;
  logic                 r_aborted;
  logic                 r_mem_full;

  logic w_idle_like;
  logic w_busy_state;
  logic w_start_ok;
  logic w_abort_ok;
  logic w_accept;
  logic w_idx_stop;
  logic w_full_stop;
  logic w_stop;
  logic w_mdr_run;
  logic w_busy;
  logic w_waiting;
  logic w_done;

  assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy_state = (r_state == S_ARM) || (r_state == S_ACQUIRE);
  assign w_start_ok   = bus.START && w_idle_like;
  assign w_abort_ok   = bus.ABORT && w_busy_state;
  // ABORT wins over a write in the same cycle, so that write is dropped.
  assign w_accept     = (r_state == S_ACQUIRE) && bus.MDR_WRITE && !bus.ABORT;
  assign w_idx_stop   = (r_index_count != 8'd0) && bus.MDR_DATA[BITS-1] &&
                        ((r_index_seen + 8'd1) == r_index_count);
  assign w_full_stop  = (r_addr == ADDR_LAST);
  assign w_stop       = w_accept && (w_idx_stop || w_full_stop);

  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.START) w_next_state = bus.WAIT_INDEX ? S_ARM : S_ACQUIRE;
      end
      S_ARM: begin
        if (bus.ABORT)            w_next_state = S_DONE;
        else if (bus.FD_INDEX_IN) w_next_state = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (bus.ABORT || w_stop) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_mdr_run = 1'b0;
    w_busy    = 1'b0;
    w_waiting = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_ARM:     begin w_busy = 1'b1; w_waiting = 1'b1; end
      S_ACQUIRE: begin w_busy = 1'b1; w_mdr_run = 1'b1; end
      S_DONE:    w_done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: the write port and counters move together on each accepted word.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_index_count <= 8'd0;
      r_addr        <= '0;
      r_ram_addr    <= '0;
      r_ram_data    <= '0;
      r_ram_we      <= 1'b0;
      r_length      <= '0;
      r_index_seen  <= 8'd0;
      r_aborted     <= 1'b0;
      r_mem_full    <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_start_ok) begin
        r_index_count <= bus.INDEX_COUNT;
        r_addr        <= '0;
        r_length      <= '0;
        r_index_seen  <= 8'd0;
        r_aborted     <= 1'b0;
        r_mem_full    <= 1'b0;
      end else if (w_abort_ok) begin
        r_aborted <= 1'b1;
      end else if (w_accept) begin
        r_ram_we   <= 1'b1;
        r_ram_addr <= r_addr;
        r_ram_data <= bus.MDR_DATA;
        r_addr     <= r_addr + ADDR_ONE;
        r_length   <= r_length + LEN_ONE;
        if (bus.MDR_DATA[BITS-1] && (r_index_seen != 8'hFF))
          r_index_seen <= r_index_seen + 8'd1;
        if (w_full_stop) r_mem_full <= 1'b1;
      end
    end
  end

  assign bus.MDR_RUN    = w_mdr_run;
  assign bus.BUSY       = w_busy;
  assign bus.WAITING    = w_waiting;
  assign bus.DONE       = w_done;
  assign bus.ABORTED    = r_aborted;
  assign bus.MEM_FULL   = r_mem_full;
  assign bus.RAM_ADDR   = r_ram_addr;
  assign bus.RAM_DATA   = r_ram_data;
  assign bus.RAM_WE     = r_ram_we;
  assign bus.INDEX_SEEN = r_index_seen;
  assign bus.LENGTH     = r_length;
  assign bus.DBG_STATE  = r_state;
endmodule
